// File: rtl/pkt_gen_pkg.sv
// Shared types and constants for the AXI-Stream packet generator.
// Stream geometry, length limit and last-beat byte-enable helper.
package pkt_gen_pkg;

   localparam int PKT_DW      = 512;
   localparam int PKT_BYTES   = PKT_DW / 8;
   localparam int PKT_MAX_LEN = 9600;
   localparam int PKT_RW      = $clog2(PKT_BYTES);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_t;

   // rem == 0 means the last beat is full
   function automatic logic [PKT_BYTES-1:0] tkeep_last(
      input logic [PKT_RW-1:0] rem
   );
      logic [PKT_BYTES-1:0] k;
      if (rem == '0) begin
         k = '1;
      end else begin
         k = ({{(PKT_BYTES-1){1'b0}}, 1'b1} << rem) - 1'b1;
      end
      return k;
   endfunction

endpackage

// File: rtl/pkt_lane_fill.sv
// Expands the payload word counter into a full stream beat.
// Lane i carries word_ctr + i, wrapping at 16 bits.
import pkt_gen_pkg::*;

module pkt_lane_fill #(
   parameter int DW = PKT_DW
) (
   input  logic [15:0]   word_ctr,
   output logic [DW-1:0] lanes
);

   always_comb begin
      lanes = '0;
      for (int i = 0; i < DW / 16; i++) begin
         lanes[16*i +: 16] = word_ctr + 16'(i);
      end
   end

endmodule

// File: rtl/packet_gen.sv
// AXI-Stream packet generator: runs of fixed-length packets with
// incrementing 16-bit payload and programmable inter-packet gaps.
import pkt_gen_pkg::*;

module packet_gen #(
   parameter int DW      = PKT_DW,
   parameter int MAX_LEN = PKT_MAX_LEN
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [15:0]     packet_len,
   input  logic [31:0]     packet_count,
   input  logic [15:0]     idle_cycles,
   input  logic [15:0]     initial_value,
   input  logic            start,
   output logic            busy,
   output logic [31:0]     packets_sent,
   output logic [DW-1:0]   AXIS_TX_TDATA,
   output logic [DW/8-1:0] AXIS_TX_TKEEP,
   output logic            AXIS_TX_TLAST,
   output logic            AXIS_TX_TVALID,
   input  logic            AXIS_TX_TREADY
);

   localparam int BYTES = DW / 8;
   localparam int LANES = DW / 16;
   localparam int RW    = $clog2(BYTES);

   state_t        state;
   logic [15:0]   beats_s;
   logic [RW-1:0] rem_s;
   logic [31:0]   cnt_s;
   logic [15:0]   idle_s;
   logic [15:0]   word_ctr;
   logic [15:0]   beat_idx;
   logic [15:0]   gap_ctr;

   logic [15:0]   len_eff;
   logic [16:0]   len_round;
   logic [15:0]   beats_in;
   logic [RW-1:0] rem_in;
   logic [15:0]   fill_base;
   logic [DW-1:0] lanes;

   logic          first;
   logic [15:0]   nxt_idx;
   logic          nxt_last;
   logic          hs;

   always_comb begin
      len_eff = packet_len;
      if (packet_len == 16'd0) begin
         len_eff = 16'd1;
      end else if (packet_len > 16'(MAX_LEN)) begin
         len_eff = 16'(MAX_LEN);
      end
   end

   assign len_round = {1'b0, len_eff} + 17'(BYTES - 1);
   assign beats_in  = 16'(len_round / 17'(BYTES));
   assign rem_in    = RW'(len_eff % 16'(BYTES));

   // Run launch uses the live seed; every later beat uses the counter
   assign fill_base = (state == IDLE) ? initial_value : word_ctr;

   pkt_lane_fill #(
      .DW(DW)
   ) u_fill (
      .word_ctr(fill_base),
      .lanes   (lanes)
   );

   assign hs       = AXIS_TX_TVALID && AXIS_TX_TREADY;
   assign first    = (state != SEND) || AXIS_TX_TLAST;
   assign nxt_idx  = first ? 16'd0 : beat_idx + 16'd1;
   assign nxt_last = (nxt_idx == beats_s - 16'd1);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state          <= IDLE;
         busy           <= 1'b0;
         packets_sent   <= '0;
         beats_s        <= '0;
         rem_s          <= '0;
         cnt_s          <= '0;
         idle_s         <= '0;
         word_ctr       <= '0;
         beat_idx       <= '0;
         gap_ctr        <= '0;
         AXIS_TX_TDATA  <= '0;
         AXIS_TX_TKEEP  <= '0;
         AXIS_TX_TLAST  <= 1'b0;
         AXIS_TX_TVALID <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && packet_count != 32'd0) begin
                  beats_s        <= beats_in;
                  rem_s          <= rem_in;
                  cnt_s          <= packet_count;
                  idle_s         <= idle_cycles;
                  packets_sent   <= '0;
                  word_ctr       <= initial_value + 16'(LANES);
                  beat_idx       <= '0;
                  AXIS_TX_TDATA  <= lanes;
                  AXIS_TX_TKEEP  <= (beats_in == 16'd1) ?
                                    tkeep_last(rem_in) : '1;
                  AXIS_TX_TLAST  <= (beats_in == 16'd1);
                  AXIS_TX_TVALID <= 1'b1;
                  busy           <= 1'b1;
                  state          <= SEND;
               end
            end
            SEND: begin
               if (hs) begin
                  if (AXIS_TX_TLAST) begin
                     packets_sent <= packets_sent + 32'd1;
                  end
                  if (AXIS_TX_TLAST &&
                      packets_sent + 32'd1 == cnt_s) begin
                     AXIS_TX_TVALID <= 1'b0;
                     AXIS_TX_TLAST  <= 1'b0;
                     busy           <= 1'b0;
                     state          <= IDLE;
                  end else if (AXIS_TX_TLAST &&
                               idle_s != 16'd0) begin
                     AXIS_TX_TVALID <= 1'b0;
                     AXIS_TX_TLAST  <= 1'b0;
                     gap_ctr        <= idle_s;
                     state          <= GAP;
                  end else begin
                     beat_idx      <= nxt_idx;
                     word_ctr      <= word_ctr + 16'(LANES);
                     AXIS_TX_TDATA <= lanes;
                     AXIS_TX_TKEEP <= nxt_last ?
                                      tkeep_last(rem_s) : '1;
                     AXIS_TX_TLAST <= nxt_last;
                  end
               end
            end
            GAP: begin
               // Next packet's first beat is loaded in the final dead cycle
               if (gap_ctr == 16'd1) begin
                  beat_idx       <= nxt_idx;
                  word_ctr       <= word_ctr + 16'(LANES);
                  AXIS_TX_TDATA  <= lanes;
                  AXIS_TX_TKEEP  <= nxt_last ?
                                    tkeep_last(rem_s) : '1;
                  AXIS_TX_TLAST  <= nxt_last;
                  AXIS_TX_TVALID <= 1'b1;
                  state          <= SEND;
               end else begin
                  gap_ctr <= gap_ctr - 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_packet_gen.sv
// Directed bench for packet_gen: vector table of runs plus
// hand-written reset, count=0 and restart sequences.
`timescale 1ns/1ps
module tb_packet_gen;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic [15:0]  packet_len = '0;
   logic [31:0]  packet_count = '0;
   logic [15:0]  idle_cycles = '0;
   logic [15:0]  initial_value = '0;
   logic         start = 1'b0;
   logic         busy;
   logic [31:0]  packets_sent;
   logic [511:0] tdata;
   logic [63:0]  tkeep;
   logic         tlast;
   logic         tvalid;
   logic         tready = 1'b0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   packet_gen #(
      .DW(512),
      .MAX_LEN(9600)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .packet_len    (packet_len),
      .packet_count  (packet_count),
      .idle_cycles   (idle_cycles),
      .initial_value (initial_value),
      .start         (start),
      .busy          (busy),
      .packets_sent  (packets_sent),
      .AXIS_TX_TDATA (tdata),
      .AXIS_TX_TKEEP (tkeep),
      .AXIS_TX_TLAST (tlast),
      .AXIS_TX_TVALID(tvalid),
      .AXIS_TX_TREADY(tready)
   );

   task automatic check(input string name, input logic [511:0] act,
                        input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] exp_data(input logic [15:0] base);
      logic [511:0] d;
      for (int i = 0; i < 32; i++) d[16*i +: 16] = base + 16'(i);
      return d;
   endfunction

   typedef struct {
      logic [15:0] len;
      logic [31:0] count;
      logic [15:0] idle;
      logic [15:0] init;
      bit          rnd;
      bit          mid;
      int          beats;
      logic [63:0] kl;
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input vec_t v, input int id);
      logic [15:0]  ctr;
      logic [511:0] pd;
      logic [63:0]  pk;
      logic         pl;
      int bidx = 0, pkts = 0, hs_total = 0, gap_cnt = 0;
      bit in_gap = 0, done = 0, hold = 0, mid_done = 0;
      string t;
      t = $sformatf("v%0d", id);
      ctr = v.init;
      pd = '0;
      pk = '0;
      pl = 1'b0;
      @(negedge clk);
      packet_len    = v.len;
      packet_count  = v.count;
      idle_cycles   = v.idle;
      initial_value = v.init;
      tready        = 1'b1;
      start         = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({t, "_busy_t1"}, 512'(busy), 512'(1));
      check({t, "_valid_t1"}, 512'(tvalid), 512'(1));
      for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
         if (hold) begin
            check({t, "_hold_data"}, tdata, pd);
            check({t, "_hold_ctl"}, 512'({tvalid, tlast, tkeep}),
                  512'({1'b1, pl, pk}));
         end
         if (in_gap && tvalid) begin
            check({t, "_gap_len"}, 512'(gap_cnt), 512'(v.idle));
            in_gap = 0;
         end else if (in_gap) begin
            gap_cnt++;
         end
         if (v.mid && hs_total == 5 && !mid_done) begin
            start = 1'b1;
            packet_len = 16'd64;
            mid_done = 1;
         end else begin
            start = 1'b0;
         end
         tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (tvalid && tready) begin
            check({t, "_data"}, tdata, exp_data(ctr));
            check({t, "_keep"}, 512'(tkeep),
                  512'((bidx == v.beats - 1) ? v.kl : ONES));
            check({t, "_last"}, 512'(tlast),
                  512'(bidx == v.beats - 1));
            ctr += 16'd32;
            hs_total++;
            if (bidx == v.beats - 1) begin
               bidx = 0;
               pkts++;
               if (pkts == int'(v.count)) begin
                  done = 1;
               end else begin
                  in_gap = 1;
                  gap_cnt = 0;
               end
            end else begin
               bidx++;
            end
         end
         hold = tvalid && !tready;
         pd = tdata;
         pk = tkeep;
         pl = tlast;
         @(negedge clk);
      end
      start = 1'b0;
      if (!done) begin
         check({t, "_timeout"}, 512'(0), 512'(1));
      end else begin
         check({t, "_busy_end"}, 512'(busy), 512'(0));
         check({t, "_valid_end"}, 512'(tvalid), 512'(0));
         check({t, "_sent"}, 512'(packets_sent), 512'(v.count));
         check({t, "_beats"}, 512'(hs_total),
               512'(int'(v.count) * v.beats));
      end
   endtask

   initial begin
      int n;
      vecs[0] = '{16'd256,   32'd3, 16'd2, 16'h0010, 0, 0,   4, ONES};
      vecs[1] = '{16'd100,   32'd1, 16'd0, 16'h0000, 0, 0,   2,
                  64'h0000_000F_FFFF_FFFF};
      vecs[2] = '{16'd64,    32'd1, 16'd0, 16'h5555, 0, 0,   1, ONES};
      vecs[3] = '{16'd128,   32'd2, 16'd0, 16'h0100, 0, 0,   2, ONES};
      vecs[4] = '{16'd0,     32'd2, 16'd1, 16'hFFF0, 0, 0,   1, 64'h1};
      vecs[5] = '{16'd10000, 32'd1, 16'd0, 16'h0000, 1, 0, 150, ONES};
      vecs[6] = '{16'd200,   32'd4, 16'd3, 16'hABCD, 1, 1,   4, 64'hFF};
      vecs[7] = '{16'd65,    32'd2, 16'd5, 16'h7FFF, 1, 0,   2, 64'h1};

      resetn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", 512'(tvalid), 512'(0));
      check("rst_busy", 512'(busy), 512'(0));
      check("rst_last", 512'(tlast), 512'(0));
      check("rst_sent", 512'(packets_sent), 512'(0));
      check("rst_data", tdata, 512'(0));
      check("rst_keep", 512'(tkeep), 512'(0));
      resetn = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // start with count=0 must not launch a run
      @(negedge clk);
      packet_len = 16'd64;
      packet_count = 32'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("cnt0_busy", 512'(busy), 512'(0));
         check("cnt0_valid", 512'(tvalid), 512'(0));
         @(negedge clk);
      end

      // reset in the middle of the second packet, then restart
      packet_len = 16'd256;
      packet_count = 32'd3;
      idle_cycles = 16'd2;
      initial_value = 16'h1234;
      tready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      for (int c = 0; c < 200 && n < 6; c++) begin
         if (tvalid) n++;
         @(negedge clk);
      end
      check("mid_reach", 512'(n), 512'(6));
      check("mid_sent_pre", 512'(packets_sent), 512'(1));
      resetn = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", 512'(tvalid), 512'(0));
      check("mid_rst_busy", 512'(busy), 512'(0));
      check("mid_rst_sent", 512'(packets_sent), 512'(0));
      resetn = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("replay_busy", 512'(busy), 512'(1));
      check("replay_valid", 512'(tvalid), 512'(1));
      check("replay_data", tdata, exp_data(16'h1234));
      check("replay_keep", 512'(tkeep), 512'(ONES));
      @(negedge clk);
      check("replay_data1", tdata, exp_data(16'h1254));
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
